// File: rtl/srlor_pkg.sv
// Shared types and constants for the SRLOR_H latch-bank driver.
package srlor_pkg;

    localparam int unsigned SYNC_DEPTH = 2;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned RETRY_W    = 3;

    typedef enum logic [3:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        SYNCW,
        CHECK,
        ACK,
        ERR,
        CLEAR
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing asynchronous latch readback into the clk domain.
module sync2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/srlor_drv.sv
// Write/clear sequencer for an external SRLOR_H latch bank with readback
// verification and bounded retry.
module srlor_drv
    import srlor_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned PULSE_W   = 2,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             wr_ack,
    output logic             wr_err,
    output logic             busy,
    output logic [WIDTH-1:0] lat_S,
    output logic             lat_E,
    output logic             lat_rst,
    input  logic [WIDTH-1:0] lat_q
);

    state_t               state;
    state_t               state_n;
    logic [CNT_W-1:0]     cnt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [WIDTH-1:0]     data_r;
    logic [WIDTH-1:0]     q_sync;
    logic                 op_clr;
    logic                 lat_rst_r;
    logic                 match_c;
    logic                 retry_ok_c;

    sync2 #(.WIDTH(WIDTH)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (lat_q),
        .q   (q_sync)
    );

    // A clear operation verifies against zero; a write against the captured word.
    assign match_c    = op_clr ? (q_sync == '0) : (q_sync == data_r);
    assign retry_ok_c = (retry_cnt < RETRY_W'(MAX_RETRY));

    // S is driven straight from the captured word, so it cannot move while E is high.
    assign lat_S   = data_r;
    assign lat_rst = rst | lat_rst_r;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (clr_req)     state_n = CLEAR;
                else if (wr_req) state_n = SETUP;
            end
            SETUP:  state_n = STROBE;
            STROBE: if (cnt == CNT_W'(PULSE_W - 1)) state_n = HOLD;
            HOLD:   state_n = SYNCW;
            SYNCW:  if (cnt == CNT_W'(SYNC_DEPTH - 1)) state_n = CHECK;
            CHECK: begin
                if (match_c)         state_n = ACK;
                else if (retry_ok_c) state_n = op_clr ? CLEAR : SETUP;
                else                 state_n = ERR;
            end
            ACK:    state_n = IDLE;
            ERR:    state_n = IDLE;
            CLEAR:  if (cnt == CNT_W'(PULSE_W - 1)) state_n = SYNCW;
            default: state_n = IDLE;
        endcase
    end

    // State, dwell counter, operation context and outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            retry_cnt <= '0;
            data_r    <= '0;
            op_clr    <= 1'b0;
            lat_E     <= 1'b0;
            lat_rst_r <= 1'b0;
            wr_ack    <= 1'b0;
            wr_err    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= (state_n == state) ? cnt + CNT_W'(1) : '0;

            if (state == IDLE && state_n == SETUP) begin
                data_r    <= wr_data;
                retry_cnt <= '0;
                op_clr    <= 1'b0;
            end
            if (state == IDLE && state_n == CLEAR) begin
                retry_cnt <= '0;
                op_clr    <= 1'b1;
            end
            if (state == CHECK && (state_n == SETUP || state_n == CLEAR)) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end

            lat_E     <= (state_n == STROBE);
            lat_rst_r <= (state_n == CLEAR);
            wr_ack    <= (state_n == ACK);
            wr_err    <= (state_n == ERR);
            busy      <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_srlor_drv.sv
// Directed bench for srlor_drv driving a behavioural SRLOR_H latch bank.
module tb_srlor_drv;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             wr_req;
    logic [WIDTH-1:0] wr_data;
    logic             clr_req;
    logic             wr_ack;
    logic             wr_err;
    logic             busy;
    logic [WIDTH-1:0] lat_S;
    logic             lat_E;
    logic             lat_rst;
    logic [WIDTH-1:0] lat_q;
    logic [WIDTH-1:0] q_lat;
    logic [WIDTH-1:0] zero_mask;

    int n_cmp;
    int n_err;

    logic [31:0] e_h;
    logic [31:0] ack_h;
    logic [31:0] err_h;
    logic [31:0] rst_h;
    logic [31:0] busy_h;

    srlor_drv #(.WIDTH(WIDTH), .PULSE_W(2), .MAX_RETRY(3)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_req  (wr_req),
        .wr_data (wr_data),
        .clr_req (clr_req),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .busy    (busy),
        .lat_S   (lat_S),
        .lat_E   (lat_E),
        .lat_rst (lat_rst),
        .lat_q   (lat_q)
    );

    // Latch bank: reset dominates, transparent while E is high.
    always_latch begin
        if (lat_rst)    q_lat = '0;
        else if (lat_E) q_lat = lat_S;
    end

    assign lat_q = q_lat & ~zero_mask;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_hist();
        e_h    = '0;
        ack_h  = '0;
        err_h  = '0;
        rst_h  = '0;
        busy_h = '0;
    endtask

    // Advance through cycles lo..hi, recording outputs; requests last one cycle.
    task automatic run(input int lo, input int hi);
        for (int c = lo; c <= hi; c++) begin
            tick();
            wr_req  = 1'b0;
            clr_req = 1'b0;
            e_h[c]    = lat_E;
            ack_h[c]  = wr_ack;
            err_h[c]  = wr_err;
            rst_h[c]  = lat_rst;
            busy_h[c] = busy;
        end
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        wr_req    = 1'b0;
        clr_req   = 1'b0;
        wr_data   = '0;
        zero_mask = '0;
        n_cmp     = 0;
        n_err     = 0;
        clr_hist();

        tick();
        tick();
        chk("rst_lat_rst", 32'(lat_rst), 32'd1);
        rst = 1'b0;
        tick();
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_lat_e",   32'(lat_E),   32'd0);
        chk("rst_ack_err", 32'({wr_ack, wr_err}), 32'd0);
        chk("rst_lat_s",   32'(lat_S),   32'h00);
        chk("rst_lat_rst_low", 32'(lat_rst), 32'd0);

        // Plain write
        wr_data = 8'hA5;
        wr_req  = 1'b1;
        clr_hist();
        run(1, 12);
        chk("wr_strobe", e_h,    32'h0000_000C);
        chk("wr_ack",    ack_h,  32'h0000_0100);
        chk("wr_busy",   busy_h, 32'h0000_01FE);
        chk("wr_err",    err_h,  32'h0);
        chk("wr_lat_q",  32'(lat_q), 32'hA5);
        chk("wr_lat_s",  32'(lat_S), 32'hA5);

        // One retry after a masked readback bit
        wr_data   = 8'h81;
        wr_req    = 1'b1;
        zero_mask = 8'h01;
        clr_hist();
        run(1, 7);
        zero_mask = 8'h00;
        run(8, 20);
        chk("retry_strobe", e_h,   32'h0000_060C);
        chk("retry_ack",    ack_h, 32'h0000_8000);
        chk("retry_err",    err_h, 32'h0);
        chk("retry_lat_q",  32'(lat_q), 32'h81);

        // Stuck-at-zero bit exhausts retries
        wr_data   = 8'hFF;
        wr_req    = 1'b1;
        zero_mask = 8'h08;
        clr_hist();
        run(1, 31);
        chk("stuck_strobe", e_h,   32'h0183_060C);
        chk("stuck_err",    err_h, 32'h2000_0000);
        chk("stuck_ack",    ack_h, 32'h0);
        chk("stuck_busy_end", 32'(busy), 32'd0);
        zero_mask = 8'h00;

        // Clear wins a collision with a write
        wr_data = 8'h3C;
        wr_req  = 1'b1;
        clr_hist();
        run(1, 10);
        chk("pre_clr_ack",  ack_h, 32'h0000_0100);
        chk("pre_clr_q",    32'(lat_q), 32'h3C);
        wr_data = 8'h77;
        wr_req  = 1'b1;
        clr_req = 1'b1;
        clr_hist();
        run(1, 8);
        chk("clr_lat_rst", rst_h, 32'h0000_0006);
        chk("clr_ack",     ack_h, 32'h0000_0040);
        chk("clr_strobe",  e_h,   32'h0);
        chk("clr_lat_q",   32'(lat_q), 32'h00);
        chk("clr_lat_s",   32'(lat_S), 32'h3C);

        // Reset during the strobe
        wr_data = 8'h5A;
        wr_req  = 1'b1;
        clr_hist();
        run(1, 2);
        chk("mid_strobe_e", 32'(lat_E), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_comb", 32'(lat_rst), 32'd1);
        clr_hist();
        run(3, 3);
        chk("mid_busy",   32'(busy),    32'd0);
        chk("mid_lat_e",  32'(lat_E),   32'd0);
        chk("mid_lat_rst", 32'(lat_rst), 32'd1);
        rst = 1'b0;
        run(4, 14);
        chk("mid_ack", ack_h, 32'h0);
        chk("mid_err", err_h, 32'h0);
        chk("mid_lat_s", 32'(lat_S), 32'h00);
        chk("mid_lat_q", 32'(lat_q), 32'h00);

        // Requests while busy are dropped
        wr_data = 8'h11;
        wr_req  = 1'b1;
        clr_hist();
        run(1, 2);
        wr_data = 8'h22;
        wr_req  = 1'b1;
        run(3, 3);
        clr_req = 1'b1;
        run(4, 4);
        wr_req  = 1'b1;
        run(5, 20);
        chk("busy_ack",    ack_h, 32'h0000_0100);
        chk("busy_strobe", e_h,   32'h0000_000C);
        chk("busy_no_clr", rst_h, 32'h0);
        chk("busy_lat_s",  32'(lat_S), 32'h11);
        chk("busy_lat_q",  32'(lat_q), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/srlor_drv.md
SRLOR_DRV -- requirements
Module: srlor_drv

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the number of SRLOR_H latch bits driven.
REQ-002 Parameter PULSE_W, default 2, SHALL set the lat_E / lat_rst strobe width in clk cycles (legal range 1..15).
REQ-003 Parameter MAX_RETRY, default 3, SHALL set the write retries allowed after a failed readback (legal range 0..7).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_req  in  1  write request, sampled in IDLE only.
REQ-007 wr_data  in  WIDTH  word to write, captured on acceptance.
REQ-008 clr_req  in  1  clear-bank request, sampled in IDLE only.
REQ-009 wr_ack  out  1  one-cycle pulse on successful write or clear.
REQ-010 wr_err  out  1  one-cycle pulse when retries are exhausted.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 lat_S  out  WIDTH  set data to the latch bank (S).
REQ-013 lat_E  out  1  latch enable strobe (E).
REQ-014 lat_rst  out  1  latch bank clear (rst).
REQ-015 lat_q  in  WIDTH  asynchronous latch readback (q).

Function
REQ-016 The FSM SHALL have the states IDLE, SETUP, STROBE, HOLD, SYNCW, CHECK, ACK, ERR and CLEAR.
REQ-017 In IDLE, with clr_req=1, the block SHALL go to CLEAR; clr_req wins when wr_req is also high.
REQ-018 In IDLE, with wr_req=1 and clr_req=0, the block SHALL capture wr_data into data_r, clear the retry count, and go to SETUP.
REQ-019 While busy=1, the block SHALL ignore wr_req and clr_req; no queuing.
REQ-020 In SETUP (1 cycle), lat_S SHALL equal data_r and lat_E SHALL be 0.
REQ-021 In STROBE (PULSE_W cycles), lat_E SHALL be 1 and lat_S SHALL equal data_r.
REQ-022 In HOLD (1 cycle), lat_E SHALL be 0 and lat_S SHALL remain data_r.
REQ-023 lat_S SHALL be stable from SETUP through HOLD, so S never changes while E is high.
REQ-024 lat_q SHALL pass through a 2-flop synchronizer; SYNCW SHALL last exactly 2 cycles.
REQ-025 In CHECK, if the synchronized q equals data_r, the block SHALL go to ACK.
REQ-026 In CHECK on a mismatch, if retry count < MAX_RETRY, the block SHALL increment the count and go to SETUP.
REQ-027 In CHECK on a mismatch, if retry count = MAX_RETRY, the block SHALL go to ERR.
REQ-028 ACK and ERR SHALL each last 1 cycle, assert wr_ack or wr_err respectively, then return to IDLE; wr_ack and wr_err SHALL never be high together.
REQ-029 Write latency with no retry: if wr_req is accepted in cycle 0, wr_ack SHALL be high in cycle PULSE_W+6.
REQ-030 Each retry SHALL add PULSE_W+5 cycles to the write latency.
REQ-031 CLEAR SHALL assert lat_rst for PULSE_W cycles with lat_E=0, then pass through SYNCW and CHECK against an all-zero word.
REQ-032 Outside CLEAR and reset, lat_rst SHALL be 0.
REQ-033 In IDLE, lat_S SHALL hold the last written data_r and lat_E SHALL be 0.
REQ-034 WIDTH=1 and all-ones / all-zeros data SHALL need no special handling.

Reset
REQ-035 While rst=1, lat_rst SHALL be driven high combinationally from rst so the latch bank clears in the same cycle.
REQ-036 After rst, state SHALL be IDLE and data_r, lat_S, retry count and the synchronizer flops SHALL all be 0.
REQ-037 After rst, lat_E, wr_ack, wr_err and busy SHALL all be 0.
REQ-038 rst asserted mid-operation SHALL abort the operation in the next cycle with no wr_ack or wr_err pulse.

Structure
REQ-039 Package srlor_pkg SHALL hold the FSM state enum and the synchronizer depth constant (2).
REQ-040 The synchronizer SHALL be a separate sub-module, sync2, parameterised by width.
REQ-041 The latch bank itself (WIDTH SRLOR_H instances) SHALL sit outside this module, in the bench or top level.

Verification
REQ-042 Write: PULSE_W=2, wr_req with wr_data=8'hA5, latches healthy -> lat_E high cycles 2-3, wr_ack in cycle 8, lat_q=8'hA5.
REQ-043 Retry: force bit0 of lat_q to 0 for the first attempt -> one retry, wr_ack in cycle 15, no wr_err.
REQ-044 Stuck bit: MAX_RETRY=3, lat_q bit3 stuck at 0, wr_data=8'hFF -> 4 strobes, then wr_err pulse; wr_ack never high.
REQ-045 Collision: clr_req and wr_req in the same IDLE cycle after writing 8'h3C -> CLEAR path, lat_rst high 2 cycles, lat_q=8'h00, wr_ack.
REQ-046 Mid-op reset: rst high during STROBE -> next cycle IDLE, lat_E=0, lat_rst=1 while rst is high, no ack/err.
REQ-047 Busy: wr_req pulsed while busy=1 -> ignored; exactly one wr_ack per accepted request.
